// File: rtl/solar_tracker_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tracker_pkg: shared types for the two-axis solar tracker scheduler.
//   tracker_state_e : scheduler FSM states (ST_FAULT only when the
//                     TRACKER_TIMEOUT_EN macro is defined)
//   dir_t / DIR_*   : direction codes sent to the pwm_control instances
//   axis_e          : which axis the next DECIDE evaluates
//   max3            : helper for sizing the shared dwell counter
// ---------------------------------------------------------------------------
package tracker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_DECIDE = 3'd2,
    ST_MOVE   = 3'd3,
    ST_SETTLE = 3'd4
`ifdef TRACKER_TIMEOUT_EN
    , ST_FAULT = 3'd5
`endif
  } tracker_state_e;

  typedef logic [1:0] dir_t;
  localparam dir_t DIR_STOP = 2'b00;
  localparam dir_t DIR_POS  = 2'b01;
  localparam dir_t DIR_NEG  = 2'b10;

  typedef enum logic {
    AXIS_H = 1'b0,
    AXIS_V = 1'b1
  } axis_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/solar_tracker_ctrl_if.sv
// ---------------------------------------------------------------------------
// solar_tracker_ctrl_if: sensor handshake, servo controls and status of the
// tracker scheduler.
//   master : the environment side (drives start, sample_valid, ldr_*)
//   slave  : the scheduler side (drives sample_req, dir_*, en_*, status)
//
// Handshake: sample_req is a one-cycle request pulse. sample_valid is a
// per-cycle qualifier for ldr_*; it is taken only while the scheduler is in
// SAMPLE (earliest in the same cycle as sample_req) and ignored otherwise.
// There is no backpressure toward the sensor front end.
// ---------------------------------------------------------------------------
interface solar_tracker_ctrl_if #(
  parameter int DATA_W = 12
);
  import tracker_pkg::*;

  logic              start;
  logic              sample_req;
  logic              sample_valid;
  logic [DATA_W-1:0] ldr_tl;
  logic [DATA_W-1:0] ldr_tr;
  logic [DATA_W-1:0] ldr_bl;
  logic [DATA_W-1:0] ldr_br;
  dir_t              dir_h;
  dir_t              dir_v;
  logic              en_h;
  logic              en_v;
  logic              busy;
  logic              locked;
  logic              fault;
  tracker_state_e    state_dbg;
  axis_e             axis_dbg;

  modport master (
    output start, sample_valid, ldr_tl, ldr_tr, ldr_bl, ldr_br,
    input  sample_req, dir_h, dir_v, en_h, en_v, busy, locked, fault,
           state_dbg, axis_dbg
  );

  modport slave (
    input  start, sample_valid, ldr_tl, ldr_tr, ldr_bl, ldr_br,
    output sample_req, dir_h, dir_v, en_h, en_v, busy, locked, fault,
           state_dbg, axis_dbg
  );

endinterface

// File: rtl/solar_tracker_ctrl_dwell_timer.sv
// ---------------------------------------------------------------------------
// dwell_timer: loadable down-counter shared by MOVE, SETTLE and the sample
// timeout. Loading N-1 makes done rise N-1 cycles later, so a state that
// leaves on done stays exactly N cycles. Holds at zero.
//   load / load_val : synchronous load (takes priority over counting)
//   done            : count is zero
// ---------------------------------------------------------------------------
module dwell_timer #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/solar_tracker_ctrl.sv
// ---------------------------------------------------------------------------
// solar_tracker_ctrl: closed-loop scheduler for the two-axis solar tracker.
// Requests an LDR sample set, compares quadrant sums for one axis at a time,
// and drives DIR/EN of the horizontal and vertical PWM generators through
// timed move/settle dwells, alternating axes.
//   clk, rst : 1 MHz clock, asynchronous active-high reset
//   bus      : solar_tracker_ctrl_if.slave (handshake, servo controls,
//              busy/locked/fault status, state/axis debug)
// Optional feature: define TRACKER_TIMEOUT_EN to add the sample-wait timeout
// and the FAULT state; otherwise fault is tied to 0.
// All outputs are registered: next values are computed alongside the next
// state and captured on the same edge.
// ---------------------------------------------------------------------------
module solar_tracker_ctrl
  import tracker_pkg::*;
#(
  parameter int DATA_W         = 12,
  parameter int DEADBAND       = 16,
  parameter int FRAME_CYCLES   = 21500,
  parameter int MOVE_FRAMES    = 4,
  parameter int SETTLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic                  clk,
  input logic                  rst,
  solar_tracker_ctrl_if.slave  bus
);

  localparam int MOVE_LEN   = MOVE_FRAMES * FRAME_CYCLES;
  localparam int SETTLE_LEN = SETTLE_FRAMES * FRAME_CYCLES;
  localparam int CNT_W      = $clog2(max3(MOVE_LEN, SETTLE_LEN, TIMEOUT_CYCLES) + 1);

  localparam logic signed [DATA_W+1:0] DB_POS = DEADBAND[DATA_W+1:0];
  localparam logic signed [DATA_W+1:0] DB_NEG = -DB_POS;

  tracker_state_e    state_q, state_d;
  axis_e             axis_q, axis_d;
  dir_t              dir_h_q, dir_h_d, dir_v_q, dir_v_d;
  logic              sample_req_q, sample_req_d;
  logic              busy_q, busy_d;
  logic              en_q, en_d;
  logic              locked_q, locked_d;
  // Previous DECIDE was balanced; two in a row (one per axis) means locked.
  logic              bal_prev_q, bal_prev_d;
  logic              capture;
  logic [DATA_W-1:0] tl_q, tr_q, bl_q, br_q;

  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_done;

  logic [DATA_W:0]          sum_a, sum_b;
  logic signed [DATA_W+1:0] diff;

`ifdef TRACKER_TIMEOUT_EN
  logic fault_q, fault_d;
`endif

  dwell_timer #(.W(CNT_W)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Horizontal compares left vs right columns, vertical compares top vs bottom.
  always_comb begin
    if (axis_q == AXIS_H) begin
      sum_a = {1'b0, tl_q} + {1'b0, bl_q};
      sum_b = {1'b0, tr_q} + {1'b0, br_q};
    end else begin
      sum_a = {1'b0, tl_q} + {1'b0, tr_q};
      sum_b = {1'b0, bl_q} + {1'b0, br_q};
    end
    diff = $signed({1'b0, sum_a}) - $signed({1'b0, sum_b});
  end

  always_comb begin
    state_d      = state_q;
    axis_d       = axis_q;
    dir_h_d      = dir_h_q;
    dir_v_d      = dir_v_q;
    sample_req_d = 1'b0;
    locked_d     = locked_q;
    bal_prev_d   = bal_prev_q;
    capture      = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;
`ifdef TRACKER_TIMEOUT_EN
    fault_d      = fault_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d      = ST_SAMPLE;
          sample_req_d = 1'b1;
`ifdef TRACKER_TIMEOUT_EN
          tmr_load     = 1'b1;
          tmr_val      = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
        end else begin
          locked_d   = 1'b0;
          bal_prev_d = 1'b0;
        end
      end
      ST_SAMPLE: begin
        if (bus.sample_valid) begin
          capture = 1'b1;
          state_d = ST_DECIDE;
        end
`ifdef TRACKER_TIMEOUT_EN
        else if (tmr_done) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end
`endif
      end
      ST_DECIDE: begin
        if ((diff > DB_POS) || (diff < DB_NEG)) begin
          state_d    = ST_MOVE;
          tmr_load   = 1'b1;
          tmr_val    = CNT_W'(MOVE_LEN - 1);
          locked_d   = 1'b0;
          bal_prev_d = 1'b0;
          if (axis_q == AXIS_H) dir_h_d = (diff > DB_POS) ? DIR_POS : DIR_NEG;
          else                  dir_v_d = (diff > DB_POS) ? DIR_POS : DIR_NEG;
        end else begin
          axis_d     = (axis_q == AXIS_H) ? AXIS_V : AXIS_H;
          bal_prev_d = 1'b1;
          if (bal_prev_q) locked_d = 1'b1;
          if (bus.start) begin
            state_d  = ST_SETTLE;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(SETTLE_LEN - 1);
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      ST_MOVE: begin
        if (tmr_done) begin
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(SETTLE_LEN - 1);
          axis_d   = (axis_q == AXIS_H) ? AXIS_V : AXIS_H;
          dir_h_d  = DIR_STOP;
          dir_v_d  = DIR_STOP;
        end
      end
      ST_SETTLE: begin
        if (tmr_done) begin
          if (bus.start) begin
            state_d      = ST_SAMPLE;
            sample_req_d = 1'b1;
`ifdef TRACKER_TIMEOUT_EN
            tmr_load     = 1'b1;
            tmr_val      = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
`ifdef TRACKER_TIMEOUT_EN
      ST_FAULT: begin
        if (!bus.start) begin
          state_d = ST_IDLE;
          fault_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        dir_h_d = DIR_STOP;
        dir_v_d = DIR_STOP;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    en_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      axis_q       <= AXIS_H;
      dir_h_q      <= DIR_STOP;
      dir_v_q      <= DIR_STOP;
      sample_req_q <= 1'b0;
      busy_q       <= 1'b0;
      en_q         <= 1'b0;
      locked_q     <= 1'b0;
      bal_prev_q   <= 1'b0;
      tl_q         <= '0;
      tr_q         <= '0;
      bl_q         <= '0;
      br_q         <= '0;
    end else begin
      state_q      <= state_d;
      axis_q       <= axis_d;
      dir_h_q      <= dir_h_d;
      dir_v_q      <= dir_v_d;
      sample_req_q <= sample_req_d;
      busy_q       <= busy_d;
      en_q         <= en_d;
      locked_q     <= locked_d;
      bal_prev_q   <= bal_prev_d;
      if (capture) begin
        tl_q <= bus.ldr_tl;
        tr_q <= bus.ldr_tr;
        bl_q <= bus.ldr_bl;
        br_q <= bus.ldr_br;
      end
    end
  end

`ifdef TRACKER_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end
  assign bus.fault = fault_q;
`else
  assign bus.fault = 1'b0;
`endif

  assign bus.sample_req = sample_req_q;
  assign bus.dir_h      = dir_h_q;
  assign bus.dir_v      = dir_v_q;
  assign bus.en_h       = en_q;
  assign bus.en_v       = en_q;
  assign bus.busy       = busy_q;
  assign bus.locked     = locked_q;
  assign bus.state_dbg  = state_q;
  assign bus.axis_dbg   = axis_q;

endmodule

// File: tb/tb_solar_tracker_ctrl.sv
// ---------------------------------------------------------------------------
// tb_solar_tracker_ctrl: directed bench for solar_tracker_ctrl with short
// frames (FRAME_CYCLES=10: move dwell 40 cycles, settle dwell 20 cycles,
// timeout 50 cycles). Inputs change and outputs are sampled on the falling
// clock edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_solar_tracker_ctrl;
  import tracker_pkg::*;

  localparam int DATA_W   = 12;
  localparam int FRAME    = 10;
  localparam int MOVE_N   = 4 * FRAME;
  localparam int SETTLE_N = 2 * FRAME;
  localparam int TMO      = 50;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  solar_tracker_ctrl_if #(.DATA_W(DATA_W)) bus ();

  solar_tracker_ctrl #(
    .DATA_W         (DATA_W),
    .DEADBAND       (16),
    .FRAME_CYCLES   (FRAME),
    .MOVE_FRAMES    (4),
    .SETTLE_FRAMES  (2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ldr(input int tl, input int tr, input int bl, input int br);
    bus.ldr_tl = DATA_W'(tl);
    bus.ldr_tr = DATA_W'(tr);
    bus.ldr_bl = DATA_W'(bl);
    bus.ldr_br = DATA_W'(br);
  endtask

  // comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " state"}, 32'(bus.state_dbg), 32'(ST_IDLE));
    check({tag, " dir_h"}, 32'(bus.dir_h), 32'(DIR_STOP));
    check({tag, " dir_v"}, 32'(bus.dir_v), 32'(DIR_STOP));
    check({tag, " en_h"}, 32'(bus.en_h), 32'd0);
    check({tag, " en_v"}, 32'(bus.en_v), 32'd0);
    check({tag, " busy"}, 32'(bus.busy), 32'd0);
    check({tag, " req"}, 32'(bus.sample_req), 32'd0);
    check({tag, " fault"}, 32'(bus.fault), 32'd0);
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.sample_valid = 1'b0;
    set_ldr(0, 0, 0, 0);
    step(3);
    rst = 1'b0;
    step(1);
    check_idle_outputs("reset");
    check("reset locked", 32'(bus.locked), 32'd0);
    check("reset axis", 32'(bus.axis_dbg), 32'(AXIS_H));

    // horizontal move: A=2000, B=1000 -> DIR_H=01
    set_ldr(1000, 500, 1000, 500);
    bus.start = 1'b1;
    step(1);
    check("h req pulse", 32'(bus.sample_req), 32'd1);
    check("h state sample", 32'(bus.state_dbg), 32'(ST_SAMPLE));
    check("h busy", 32'(bus.busy), 32'd1);
    bus.sample_valid = 1'b1;
    step(1);
    bus.sample_valid = 1'b0;
    check("h req drop", 32'(bus.sample_req), 32'd0);
    check("h decide", 32'(bus.state_dbg), 32'(ST_DECIDE));
    check("h dir before", 32'(bus.dir_h), 32'(DIR_STOP));
    step(1);
    check("h dir_h move", 32'(bus.dir_h), 32'(DIR_POS));
    check("h dir_v idle axis", 32'(bus.dir_v), 32'(DIR_STOP));
    check("h en", 32'({bus.en_h, bus.en_v}), 32'd3);
    step(MOVE_N - 1);
    check("h move last", 32'(bus.state_dbg), 32'(ST_MOVE));
    check("h dir_h last", 32'(bus.dir_h), 32'(DIR_POS));
    step(1);
    check("h settle", 32'(bus.state_dbg), 32'(ST_SETTLE));
    check("h settle dir", 32'(bus.dir_h), 32'(DIR_STOP));
    check("h axis toggled", 32'(bus.axis_dbg), 32'(AXIS_V));
    step(SETTLE_N - 1);
    check("h settle last", 32'(bus.state_dbg), 32'(ST_SETTLE));
    check("h settle req", 32'(bus.sample_req), 32'd0);
    step(1);
    check("h resample req", 32'(bus.sample_req), 32'd1);

    // vertical move: A=1000, B=2000 -> DIR_V=10, then START dropped mid-move
    set_ldr(500, 500, 1000, 1000);
    bus.sample_valid = 1'b1;
    step(1);
    bus.sample_valid = 1'b0;
    step(1);
    check("v dir_v", 32'(bus.dir_v), 32'(DIR_NEG));
    check("v dir_h", 32'(bus.dir_h), 32'(DIR_STOP));
    step(5);
    bus.start = 1'b0;
    step(MOVE_N - 6);
    check("v move holds", 32'(bus.dir_v), 32'(DIR_NEG));
    check("v move en", 32'(bus.en_v), 32'd1);
    step(1);
    check("v settle dir", 32'(bus.dir_v), 32'(DIR_STOP));
    check("v settle en", 32'({bus.en_h, bus.en_v}), 32'd3);
    step(SETTLE_N - 1);
    check("v settle last en", 32'(bus.en_h), 32'd1);
    step(1);
    check_idle_outputs("v stop");
    check("v axis back", 32'(bus.axis_dbg), 32'(AXIS_H));

    // balanced both axes: d=0 then d=16 -> no move, locked
    set_ldr(800, 800, 800, 800);
    bus.start = 1'b1;
    step(1);
    bus.sample_valid = 1'b1;
    step(1);
    bus.sample_valid = 1'b0;
    step(1);
    check("bal1 settle", 32'(bus.state_dbg), 32'(ST_SETTLE));
    check("bal1 dir", 32'({bus.dir_h, bus.dir_v}), 32'd0);
    check("bal1 locked", 32'(bus.locked), 32'd0);
    check("bal1 axis", 32'(bus.axis_dbg), 32'(AXIS_V));
    step(SETTLE_N);
    check("bal2 req", 32'(bus.sample_req), 32'd1);
    set_ldr(808, 808, 800, 800);
    bus.sample_valid = 1'b1;
    step(1);
    bus.sample_valid = 1'b0;
    step(1);
    check("bal2 settle", 32'(bus.state_dbg), 32'(ST_SETTLE));
    check("bal2 dir", 32'({bus.dir_h, bus.dir_v}), 32'd0);
    check("bal2 locked", 32'(bus.locked), 32'd1);

    // d=17 on horizontal axis: just outside the deadband -> move, unlock
    step(SETTLE_N);
    set_ldr(817, 800, 800, 800);
    bus.sample_valid = 1'b1;
    step(1);
    bus.sample_valid = 1'b0;
    step(1);
    check("d17 dir_h", 32'(bus.dir_h), 32'(DIR_POS));
    check("d17 unlock", 32'(bus.locked), 32'd0);

    // asynchronous reset mid-move
    step(5);
    #2 rst = 1'b1;
    #1;
    check("arst dir_h", 32'(bus.dir_h), 32'(DIR_STOP));
    check("arst en", 32'({bus.en_h, bus.en_v}), 32'd0);
    check("arst busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    step(1);
    rst = 1'b0;
    step(3);
    check_idle_outputs("post arst");
    check("post arst axis", 32'(bus.axis_dbg), 32'(AXIS_H));

`ifdef TRACKER_TIMEOUT_EN
    // no sample_valid for TMO cycles -> FAULT
    bus.start = 1'b1;
    step(1);
    check("tmo sample", 32'(bus.state_dbg), 32'(ST_SAMPLE));
    step(TMO - 1);
    check("tmo not yet", 32'(bus.fault), 32'd0);
    step(1);
    check("tmo fault", 32'(bus.fault), 32'd1);
    check("tmo busy", 32'(bus.busy), 32'd1);
    check("tmo en", 32'({bus.en_h, bus.en_v}), 32'd3);
    check("tmo dir", 32'({bus.dir_h, bus.dir_v}), 32'd0);
    bus.start = 1'b0;
    step(1);
    check_idle_outputs("tmo exit");
`else
    // without the timeout, SAMPLE waits indefinitely and fault stays 0
    bus.start = 1'b1;
    step(TMO + 10);
    check("wait sample", 32'(bus.state_dbg), 32'(ST_SAMPLE));
    check("wait fault", 32'(bus.fault), 32'd0);
    set_ldr(800, 800, 800, 800);
    bus.start = 1'b0;
    bus.sample_valid = 1'b1;
    step(1);
    bus.sample_valid = 1'b0;
    step(1);
    check_idle_outputs("wait exit");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
